// File: rtl/prg_saver_if.sv
// ---------------------------------------------------------------------------
// prg_saver_if : DMA read port plus outbound .PRG byte stream   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface prg_saver_if;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_din;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_idx;
  logic [16:0] out_len;

  // master = the saver; slave = RAM/DMA port and upload consumer
  modport master (
    output dma_addr, dma_rd, out_data, out_valid, out_idx, out_len,
    input  dma_din, out_ready
  );

  modport slave (
    input  dma_addr, dma_rd, out_data, out_valid, out_idx, out_len,
    output dma_din, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/prg_saver.sv
// ---------------------------------------------------------------------------
// prg_saver : serialise resident BASIC program from PET RAM as .PRG stream (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module prg_saver #(
  parameter int          DMA_LAT  = 1,
  parameter logic [15:0] PTR_BASE = 16'h0028,
  parameter logic [15:0] MAX_END  = 16'h8000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  prg_saver_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PTR   = 3'd1,
    S_CHECK = 3'd2,
    S_HDR   = 3'd3,
    S_FETCH = 3'd4,
    S_SEND  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [1:0] LAT = 2'(DMA_LAT);

  state_t      state_q,     state_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        err_q,       err_d;
  logic        dma_rd_q,    dma_rd_d;
  logic [15:0] dma_addr_q,  dma_addr_d;
  logic [7:0]  out_data_q,  out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [16:0] out_idx_q,   out_idx_d;
  logic [16:0] out_len_q,   out_len_d;
  logic [15:0] prg_start_q, prg_start_d;
  logic [15:0] prg_end_q,   prg_end_d;
  logic [15:0] cur_q,       cur_d;
  logic [1:0]  ptr_sel_q,   ptr_sel_d;
  logic [1:0]  wait_q,      wait_d;

  logic        accept;
  logic [15:0] cur_next;

  assign accept   = out_valid_q & bus.out_ready;
  assign cur_next = cur_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    dma_rd_d    = 1'b0;
    dma_addr_d  = dma_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_len_d   = out_len_q;
    prg_start_d = prg_start_q;
    prg_end_d   = prg_end_q;
    cur_d       = cur_q;
    ptr_sel_d   = ptr_sel_q;
    wait_d      = wait_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PTR;
          busy_d     = 1'b1;
          dma_rd_d   = 1'b1;
          dma_addr_d = PTR_BASE;
          ptr_sel_d  = 2'd0;
          wait_d     = 2'd0;
        end
      end

      S_PTR: begin
        if (wait_q == LAT) begin
          case (ptr_sel_q)
            2'd0:    prg_start_d[7:0]  = bus.dma_din;
            2'd1:    prg_start_d[15:8] = bus.dma_din;
            2'd2:    prg_end_d[7:0]    = bus.dma_din;
            default: prg_end_d[15:8]   = bus.dma_din;
          endcase
          if (ptr_sel_q == 2'd3) begin
            state_d = S_CHECK;
          end else begin
            ptr_sel_d  = ptr_sel_q + 2'd1;
            dma_addr_d = dma_addr_q + 16'd1;
            dma_rd_d   = 1'b1;
            wait_d     = 2'd0;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_CHECK: begin
        if ((prg_end_q < prg_start_q) || (prg_end_q > MAX_END)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d     = S_HDR;
          out_len_d   = {1'b0, prg_end_q} - {1'b0, prg_start_q} + 17'd2;
          out_data_d  = prg_start_q[7:0];
          out_idx_d   = 17'd0;
          out_valid_d = 1'b1;
          cur_d       = prg_start_q;
        end
      end

      S_HDR: begin
        if (accept) begin
          if (!out_idx_q[0]) begin
            out_data_d = prg_start_q[15:8];
            out_idx_d  = 17'd1;
          end else begin
            out_idx_d   = 17'd2;
            out_valid_d = 1'b0;
            if (cur_q == prg_end_q) begin
              state_d = S_FIN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d    = S_FETCH;
              dma_rd_d   = 1'b1;
              dma_addr_d = cur_q;
              wait_d     = 2'd0;
            end
          end
        end
      end

      S_FETCH: begin
        if (wait_q == LAT) begin
          state_d     = S_SEND;
          out_data_d  = bus.dma_din;
          out_valid_d = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_SEND: begin
        if (accept) begin
          out_valid_d = 1'b0;
          out_idx_d   = out_idx_q + 17'd1;
          cur_d       = cur_next;
          // the read address is only ever loaded from a cur that is below end
          if (cur_next == prg_end_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = S_FETCH;
            dma_rd_d   = 1'b1;
            dma_addr_d = cur_next;
            wait_d     = 2'd0;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // abort overrides everything, including a final accept
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      dma_rd_d    = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dma_rd_q    <= 1'b0;
      dma_addr_q  <= 16'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 17'd0;
      out_len_q   <= 17'd0;
      prg_start_q <= 16'd0;
      prg_end_q   <= 16'd0;
      cur_q       <= 16'd0;
      ptr_sel_q   <= 2'd0;
      wait_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dma_rd_q    <= dma_rd_d;
      dma_addr_q  <= dma_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_len_q   <= out_len_d;
      prg_start_q <= prg_start_d;
      prg_end_q   <= prg_end_d;
      cur_q       <= cur_d;
      ptr_sel_q   <= ptr_sel_d;
      wait_q      <= wait_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.dma_rd    = dma_rd_q;
  assign bus.dma_addr  = dma_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_len   = out_len_q;

endmodule

`default_nettype wire

// File: tb/tb_prg_saver.sv
// ---------------------------------------------------------------------------
// tb_prg_saver : directed bench for prg_saver at DMA_LAT 1 and 3   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prg_saver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_a, abort_a, busy_a, done_a, err_a;
  logic start_b, abort_b, busy_b, done_b, err_b;

  prg_saver_if bus_a ();
  prg_saver_if bus_b ();

  prg_saver #(.DMA_LAT(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .err(err_a), .bus(bus_a)
  );

  prg_saver #(.DMA_LAT(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .err(err_b), .bus(bus_b)
  );

  logic [7:0] ram [0:65535];

  // read data is X unless it is exactly DMA_LAT cycles after a strobe
  always @(posedge clk) bus_a.dma_din <= bus_a.dma_rd ? ram[bus_a.dma_addr] : 8'hxx;

  logic [7:0] pb0 = 8'hxx, pb1 = 8'hxx;
  always @(posedge clk) begin
    pb0           <= bus_b.dma_rd ? ram[bus_b.dma_addr] : 8'hxx;
    pb1           <= pb0;
    bus_b.dma_din <= pb1;
  end

  logic [7:0]  q_a [$];
  int          i_a [$];
  logic [7:0]  q_b [$];
  int          i_b [$];
  int          done_a_cnt = 0, err_a_cnt = 0, valid_a_cnt = 0, rd_a_cnt = 0, viol_a = 0;
  int          done_b_cnt = 0, stab_err_b = 0;
  logic [15:0] lim_a;
  logic        prev_stall_b = 1'b0;
  logic [7:0]  prev_data_b  = 8'd0;
  logic [16:0] prev_idx_b   = 17'd0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (bus_a.out_valid && bus_a.out_ready) begin
        q_a.push_back(bus_a.out_data);
        i_a.push_back(int'(bus_a.out_idx));
      end
      if (done_a)          done_a_cnt  <= done_a_cnt + 1;
      if (err_a)           err_a_cnt   <= err_a_cnt + 1;
      if (bus_a.out_valid) valid_a_cnt <= valid_a_cnt + 1;
      if (bus_a.dma_rd) begin
        rd_a_cnt <= rd_a_cnt + 1;
        if (bus_a.dma_addr >= lim_a &&
            !(bus_a.dma_addr >= 16'h0028 && bus_a.dma_addr <= 16'h002B))
          viol_a <= viol_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (bus_b.out_valid && bus_b.out_ready) begin
        q_b.push_back(bus_b.out_data);
        i_b.push_back(int'(bus_b.out_idx));
      end
      if (done_b) done_b_cnt <= done_b_cnt + 1;
      if (prev_stall_b && (!bus_b.out_valid || bus_b.out_data !== prev_data_b ||
                           bus_b.out_idx !== prev_idx_b))
        stab_err_b <= stab_err_b + 1;
      prev_stall_b <= bus_b.out_valid && !bus_b.out_ready;
      prev_data_b  <= bus_b.out_data;
      prev_idx_b   <= bus_b.out_idx;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes [0:5] = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input logic [7:0] dq[$], input int iq[$],
                              input int base, input int n);
    check({tag, "_count"}, dq.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (base + k < dq.size()) begin
        check($sformatf("%s_byte%0d", tag, k), dq[base + k], exp_bytes[k]);
        check($sformatf("%s_idx%0d", tag, k), iq[base + k], k);
      end
    end
  endtask

  task automatic pulse_start_a(input string tag);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check({tag, "_busy_after_start"}, busy_a, 1);
  endtask

  // waits for done or err on A; checks busy/out_valid at the pulse cycle
  task automatic wait_end_a(input string tag, input int budget, output bit got_done, output bit got_err);
    bit hit = 1'b0;
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_a || err_a) begin
        hit      = 1'b1;
        got_done = done_a;
        got_err  = err_a;
        check({tag, "_busy_at_end"}, busy_a, 0);
        check({tag, "_valid_at_end"}, bus_a.out_valid, 0);
        break;
      end
    end
    check({tag, "_end_seen"}, hit, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int  base, d0, e0, v0, r0;
    bit  gd, ge, hit;

    for (int k = 0; k < 65536; k++) ram[k] = 8'h00;
    ram[16'h0028] = 8'h01; ram[16'h0029] = 8'h04;
    ram[16'h002A] = 8'h05; ram[16'h002B] = 8'h04;
    ram[16'h0401] = 8'hAA; ram[16'h0402] = 8'hBB;
    ram[16'h0403] = 8'hCC; ram[16'h0404] = 8'hDD;
    ram[16'h0405] = 8'hEE;

    reset_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b0;
    lim_a = 16'h0405;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy_a, done_a, err_a, bus_a.dma_rd, bus_a.out_valid}, 0);
    check("rst_addr", bus_a.dma_addr, 0);
    check("rst_data", bus_a.out_data, 0);
    check("rst_idx",  bus_a.out_idx, 0);
    check("rst_len",  bus_a.out_len, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // normal 4-byte program
    base = q_a.size(); d0 = done_a_cnt;
    pulse_start_a("t1");
    wait_end_a("t1", 200, gd, ge);
    check("t1_done", gd, 1);
    check_stream("t1", q_a, i_a, base, 6);
    check("t1_len", bus_a.out_len, 6);
    check("t1_done_cnt", done_a_cnt - d0, 1);
    check("t1_addr_bound", viol_a, 0);

    // empty program: header only, no body reads
    ram[16'h002A] = 8'h01;
    lim_a = 16'h0401;
    base = q_a.size(); r0 = rd_a_cnt;
    pulse_start_a("t2");
    wait_end_a("t2", 200, gd, ge);
    check("t2_done", gd, 1);
    check_stream("t2", q_a, i_a, base, 2);
    check("t2_len", bus_a.out_len, 2);
    check("t2_rd_cnt", rd_a_cnt - r0, 4);
    check("t2_addr_bound", viol_a, 0);

    // end < start
    ram[16'h002A] = 8'h00;
    lim_a = 16'h0000;
    base = q_a.size(); v0 = valid_a_cnt; e0 = err_a_cnt; d0 = done_a_cnt;
    pulse_start_a("t3a");
    wait_end_a("t3a", 200, gd, ge);
    check("t3a_err", ge, 1);
    check("t3a_no_done", done_a_cnt - d0, 0);
    check("t3a_no_valid", valid_a_cnt - v0, 0);
    check("t3a_no_bytes", q_a.size() - base, 0);

    // end beyond RAM top
    ram[16'h002A] = 8'h01; ram[16'h002B] = 8'h80;
    v0 = valid_a_cnt;
    pulse_start_a("t3b");
    wait_end_a("t3b", 200, gd, ge);
    check("t3b_err", ge, 1);
    check("t3b_no_valid", valid_a_cnt - v0, 0);
    check("t3b_err_cnt", err_a_cnt - e0, 2);
    check("t3b_addr_bound", viol_a, 0);

    // random backpressure on the DMA_LAT=3 instance
    ram[16'h002A] = 8'h05; ram[16'h002B] = 8'h04;
    lim_a = 16'h0405;
    base = q_b.size(); d0 = done_b_cnt;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("t4_busy_after_start", busy_b, 1);
    hit = 1'b0;
    for (int k = 0; k < 800; k++) begin
      bus_b.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done_b) begin
        hit = 1'b1;
        check("t4_valid_at_done", bus_b.out_valid, 0);
        break;
      end
    end
    check("t4_end_seen", hit, 1);
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    check_stream("t4", q_b, i_b, base, 6);
    check("t4_len", bus_b.out_len, 6);
    check("t4_done_cnt", done_b_cnt - d0, 1);
    check("t4_stable", stab_err_b, 0);

    // abort after idx 3 accepted
    base = q_a.size(); d0 = done_a_cnt;
    pulse_start_a("t5");
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (q_a.size() - base >= 4) begin hit = 1'b1; break; end
    end
    check("t5_reach_idx3", hit, 1);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("t5_busy_after_abort", busy_a, 0);
    check("t5_valid_after_abort", bus_a.out_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_done", done_a_cnt - d0, 0);
    check("t5_bytes", q_a.size() - base, 4);
    check("t5_idle_rd", bus_a.dma_rd, 0);
    base = q_a.size();
    pulse_start_a("t5r");
    wait_end_a("t5r", 200, gd, ge);
    check("t5r_done", gd, 1);
    check_stream("t5r", q_a, i_a, base, 6);

    // async reset in the middle of a body fetch
    pulse_start_a("t6");
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (bus_a.dma_rd && bus_a.dma_addr == 16'h0402) begin hit = 1'b1; break; end
    end
    check("t6_reach_fetch", hit, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {busy_a, done_a, err_a, bus_a.dma_rd, bus_a.out_valid}, 0);
    check("t6_rst_addr", bus_a.dma_addr, 0);
    check("t6_rst_data", bus_a.out_data, 0);
    check("t6_rst_idx",  bus_a.out_idx, 0);
    check("t6_rst_len",  bus_a.out_len, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    base = q_a.size(); d0 = done_a_cnt;
    pulse_start_a("t6r");
    wait_end_a("t6r", 200, gd, ge);
    check("t6r_done", gd, 1);
    check_stream("t6r", q_a, i_a, base, 6);
    check("t6r_len", bus_a.out_len, 6);
    check("t6r_done_cnt", done_a_cnt - d0, 1);
    check("t6r_addr_bound", viol_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
